// File: rtl/sub16_seq.sv
// sub16_seq: sequential 16-bit subtractor, one 4-bit slice per clock, LSB first.
// A-B is formed as A + ~B + 1, with the +1 injected as the initial slice carry.
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   begin A-B; accepted on a rising edge while busy=0
//   A, B   in   16-bit operands, latched on the accepting edge
//   busy   out  operation in progress
//   done   out  one-cycle completion pulse
//   DIFF   out  A-B mod 2^16, held until the next completion
//   BO     out  borrow out (A<B unsigned), held like DIFF
//   OVF    out  signed overflow, present only when SUB16_SEQ_OVF_EN is defined
//
// Configuration: define SUB16_SEQ_OVF_EN to add the OVF port and its logic.

module sub16_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] A,
  input  logic [15:0] B,
  output logic        busy,
  output logic        done,
  output logic [15:0] DIFF,
  output logic        BO
`ifdef SUB16_SEQ_OVF_EN
  ,
  output logic        OVF
`endif
);

  localparam int unsigned W     = 16;
  localparam int unsigned SW    = 4;
  localparam int unsigned CNT_W = 2;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [W-1:0]     diff_q, diff_d;
  logic             bo_q, bo_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
`ifdef SUB16_SEQ_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [3:0]    idx_c;
  logic [SW-1:0] a_nib_c;
  logic [SW-1:0] b_nib_c;
  logic [SW:0]   sum_c;

  // Current slice: operand nibbles selected by the counter, plus carry chain
  always_comb begin
    idx_c   = {cnt_q, 2'b00};
    a_nib_c = a_q[idx_c +: SW];
    b_nib_c = b_q[idx_c +: SW];
    sum_c   = {1'b0, a_nib_c} + {1'b0, ~b_nib_c} + {4'b0000, carry_q};
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef SUB16_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
`ifdef SUB16_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
`ifdef SUB16_SEQ_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          cnt_d   = '0;
          carry_d = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        acc_d[idx_c +: SW] = sum_c[SW-1:0];
        carry_d            = sum_c[SW];
        cnt_d              = cnt_q + CNT_W'(1);
        // Last slice: publish the whole result at once so DIFF never shows partials
        if (cnt_q == CNT_W'(3)) begin
          diff_d  = {sum_c[SW-1:0], acc_q[11:0]};
          bo_d    = ~sum_c[SW];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
`ifdef SUB16_SEQ_OVF_EN
          ovf_d   = (a_q[W-1] != b_q[W-1]) && (sum_c[SW-1] != a_q[W-1]);
`endif
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign DIFF = diff_q;
  assign BO   = bo_q;
`ifdef SUB16_SEQ_OVF_EN
  assign OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_sub16_seq.sv
// Directed testbench for sub16_seq: hand-computed vectors, latency, busy/start
// interaction, mid-run reset and back-to-back operation.

module tb_sub16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic        busy;
  logic        done;
  logic [15:0] DIFF;
  logic        BO;
`ifdef SUB16_SEQ_OVF_EN
  logic        OVF;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  sub16_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .DIFF  (DIFF),
    .BO    (BO)
`ifdef SUB16_SEQ_OVF_EN
    ,
    .OVF   (OVF)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full operation with latency and hold checks; prev_d is the DIFF shown before completion
  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_d, input logic exp_bo,
                        input logic exp_ovf, input logic [15:0] prev_d);
    A     = a;
    B     = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    A     = ~a;
    B     = ~b;
    check("accept_busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("run_done_low", 32'(done), 32'd0);
      check("run_diff_hold", 32'(DIFF), 32'(prev_d));
    end
    tick();
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy_low", 32'(busy), 32'd0);
    check("diff", 32'(DIFF), 32'(exp_d));
    check("bo", 32'(BO), 32'(exp_bo));
`ifdef SUB16_SEQ_OVF_EN
    check("ovf", 32'(OVF), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unreachable");
`endif
    tick();
    check("done_single", 32'(done), 32'd0);
    check("diff_held", 32'(DIFF), 32'(exp_d));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(DIFF), 32'd0);
    check("rst_bo", 32'(BO), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed vectors: a, b, diff, bo, ovf
    run_op(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 16'h0000);
    run_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 16'h1000);
    run_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 16'hFFFF);
    run_op(16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 16'h7FFF);
    run_op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 16'h0FFF);
    run_op(16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 16'h8000);

    // start during RUN is ignored; operands stay latched; single done pulse
    A = 16'h1234; B = 16'h0234; start = 1'b1;
    tick();                                   // t0
    start = 1'b0;
    tick();                                   // t1
    A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
    tick();                                   // t2: ignored
    start = 1'b0;
    check("busy_ign_t2", 32'(busy), 32'd1);
    check("done_ign_t2", 32'(done), 32'd0);
    tick();                                   // t3
    check("done_ign_t3", 32'(done), 32'd0);
    tick();                                   // t4
    check("ign_done", 32'(done), 32'd1);
    check("ign_diff", 32'(DIFF), 32'h1000);
    check("ign_bo", 32'(BO), 32'd0);
    tick();
    check("ign_single", 32'(done), 32'd0);
    check("ign_idle", 32'(busy), 32'd0);

    // Reset during RUN aborts: immediate reset values, no done pulse
    A = 16'h0000; B = 16'h0001; start = 1'b1;
    tick();                                   // t0
    start = 1'b0;
    tick();                                   // t1
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_diff", 32'(DIFF), 32'd0);
    check("abort_bo", 32'(BO), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_no_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_idle", 32'(done | busy), 32'd0);
    end

    // First start after reset is accepted normally
    run_op(16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 16'h0000);

    // Back-to-back: start held high across the done cycle
    A = 16'h5555; B = 16'h0055; start = 1'b1;
    tick();                                   // t0
    start = 1'b0;
    tick(); tick(); tick();                   // t1..t3
    A = 16'h0010; B = 16'h0001; start = 1'b1;
    tick();                                   // t4: completion, start ignored (busy)
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_diff1", 32'(DIFF), 32'h5500);
    tick();                                   // t5: accepted
    start = 1'b0;
    A = 16'hAAAA; B = 16'hBBBB;
    check("b2b_busy", 32'(busy), 32'd1);
    check("b2b_done_low", 32'(done), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b2b_hold", 32'(DIFF), 32'h5500);
      check("b2b_no_done", 32'(done), 32'd0);
    end
    tick();                                   // t9
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_diff2", 32'(DIFF), 32'h000F);
    check("b2b_bo2", 32'(BO), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sub16_seq.md
SUB16_SEQ -- requirements
Module: sub16_seq

Interface
REQ-001 Parameters: none; width is fixed at 16 bits, processed as four 4-bit slices.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin A-B; sampled on a rising edge while busy=0.
REQ-005 A  input  16  minuend, unsigned or two's complement; sampled only on the accepting edge.
REQ-006 B  input  16  subtrahend; sampled only on the accepting edge.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 done  output  1  single-cycle pulse; DIFF/BO (and OVF) are valid when high.
REQ-009 DIFF  output  16  A-B modulo 2^16; held from done until the next completion.
REQ-010 BO  output  1  borrow out: 1 iff A<B unsigned; held like DIFF.
REQ-011 OVF  output  1  signed overflow; present only when SUB16_SEQ_OVF_EN is defined.

Function
REQ-012 FSM states: IDLE and RUN; a 2-bit slice counter selects the nibble.
REQ-013 IDLE: start=1 at an edge latches A and B, clears the counter, sets internal carry=1, enters RUN, and sets busy=1.
REQ-014 RUN: each edge computes slice k: DIFF_int[4k+3:4k] = A[4k+3:4k] + ~B[4k+3:4k] + carry; carry takes that slice's carry-out; k increments.
REQ-015 Slices are processed LSB first, k=0..3; exactly one slice per cycle.
REQ-016 Processing slice 3 transfers DIFF_int to DIFF, sets BO=~carry_out, asserts done for one cycle, clears busy, and returns to IDLE.
REQ-017 Latency: start accepted at edge t0; done=1 and results valid after edge t4; busy=1 only between edges t0 and t4.
REQ-018 start while busy=1 is ignored; the latched operands are unaffected.
REQ-019 start=1 in the cycle done=1 is accepted (back-to-back; no idle cycle required).
REQ-020 A, B changes after the accepting edge have no effect on the result.
REQ-021 DIFF, BO and OVF change only on a completing edge and never show partial results.
REQ-022 done is low in every cycle other than the completion cycle.

Reset
REQ-023 rst_n=0 forces, immediately: state=IDLE, busy=0, done=0, DIFF=16'h0000, BO=0, OVF=0 (if present), counter=0, carry=1.
REQ-024 Reset during RUN aborts the operation: no done pulse, and outputs show reset values.
REQ-025 After rst_n deasserts, the first rising edge with start=1 is accepted normally.

Configuration
REQ-026 Macro SUB16_SEQ_OVF_EN defined: OVF port exists and is set at completion to (A[15]!=B[15]) && (DIFF[15]!=A[15]), held like DIFF.
REQ-027 Macro SUB16_SEQ_OVF_EN undefined: OVF port and its logic are absent; all other behaviour is identical.

Verification
REQ-028 A=16'h1234, B=16'h0234, start pulse -> done after 4 edges, DIFF=16'h1000, BO=0, OVF=0.
REQ-029 A=16'h0000, B=16'h0001 -> DIFF=16'hFFFF, BO=1, OVF=0; with A=16'h8000, B=16'h0001 -> DIFF=16'h7FFF, BO=0, OVF=1 (macro defined).
REQ-030 start again with A=16'hFFFF, B=16'hFFFF at edge t2 of a running op -> ignored; first result unchanged; one done pulse only.
REQ-031 rst_n low at edge t2 of RUN -> busy=0, DIFF=0, BO=0 immediately; no done pulse.
REQ-032 Back-to-back: start held high across a done cycle with new A=16'h0010, B=16'h0001 -> second done 4 edges later, DIFF=16'h000F; DIFF holds the first result in between.
